// File: rtl/bus_deserializer.sv
// Serial-to-parallel receiver: rebuilds MSB-first DATA_WIDTH-bit words and
// presents each one in a holding register on a valid/ready handshake.
module bus_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n, overrun_n, busy_n;
    logic                  complete, transfer;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        data_n    = data_out;
        valid_n   = data_valid;
        overrun_n = overrun;
        complete  = 1'b0;
        transfer  = data_valid && data_ready;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    shift_n   = {{(DATA_WIDTH-1){1'b0}}, serial_in};
                    bit_cnt_n = CNT_W'(1);
                    state_n   = RECV;
                end
            end
            RECV: begin
                if (enable) begin
                    shift_n = {shift_reg[DATA_WIDTH-2:0], serial_in};
                    if (bit_cnt == LAST_BIT) begin
                        complete  = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    // dropping enable throws away the partial word only
                    shift_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A completed word may only replace the holding register if it is empty
        // or being drained on this very edge; otherwise the new word is lost.
        if (complete) begin
            if (!data_valid || transfer) begin
                data_n  = shift_n;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end else if (transfer) begin
            valid_n = 1'b0;
        end

        if (complete && data_valid && !transfer) begin
            overrun_n = 1'b1;
        end else if (clr_overrun) begin
            overrun_n = 1'b0;
        end

        busy_n = (bit_cnt_n != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_n;
            data_out   <= data_n;
            data_valid <= valid_n;
            overrun    <= overrun_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_bus_deserializer.sv
// Directed bench for bus_deserializer: a vector table for single-word and
// aborted-word traffic, then hand sequences for loopback, overrun, handshake and reset.
module tb_bus_deserializer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       overrun;
    logic       clr_overrun;

    int n_vec;
    int n_err;

    bus_deserializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       sin;
        logic       rdy;
        logic       clr;
        logic [7:0] d;
        logic       v;
        logic       b;
        logic       o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, sin, rdy, clr,
                                input logic [7:0] d, input logic v, b, o);
        vec_t r;
        r.en = en; r.sin = sin; r.rdy = rdy; r.clr = clr;
        r.d = d; r.v = v; r.b = b; r.o = o;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_body,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            enable      = 1'b1;
            serial_in   = w[7-i];
            data_ready  = (i == 7) ? rdy_last : rdy_body;
            clr_overrun = (i == 7) ? clr_last : 1'b0;
            tick();
        end
        enable      = 1'b0;
        serial_in   = 1'b0;
        data_ready  = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        logic [7:0] lb_words[3];
        logic [7:0] bits;
        logic       tx_en, tx_bit, prev_en, prev_bit;
        int         got, last_cyc;

        n_vec = 0;
        n_err = 0;
        rst = 1'b0; enable = 1'b0; serial_in = 1'b0;
        data_ready = 1'b0; clr_overrun = 1'b0;

        #12;
        chk("reset data_out", data_out, 8'h00);
        chk("reset data_valid", data_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        rst = 1'b1;

        // T1: 8'hA5 with ready held high
        bits = 8'hA5;
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1'b1, bits[7-i], 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, bits[0], 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
        // T3: 3-bit partial word aborted, then 8'h81
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
        bits = 8'h81;
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1'b1, bits[7-i], 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, bits[0], 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            enable      = tbl[i].en;
            serial_in   = tbl[i].sin;
            data_ready  = tbl[i].rdy;
            clr_overrun = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d data_out", i), data_out, tbl[i].d);
            chk($sformatf("vec%0d data_valid", i), data_valid, tbl[i].v);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d overrun", i), overrun, tbl[i].o);
        end

        // T2: loopback through a registered serializer model, rx enable = tx enable delayed 1
        lb_words[0] = 8'h3C; lb_words[1] = 8'hFF; lb_words[2] = 8'h00;
        prev_en = 1'b0; prev_bit = 1'b0; got = 0; last_cyc = 0;
        data_ready = 1'b1;
        for (int c = 0; c < 28; c++) begin
            tx_en  = (c < 24);
            bits   = lb_words[(c < 24) ? c / 8 : 0];
            tx_bit = tx_en ? bits[7 - (c % 8)] : 1'b0;
            enable    = prev_en;
            serial_in = prev_bit;
            tick();
            prev_en  = tx_en;
            prev_bit = tx_bit;
            if (data_valid) begin
                if (got < 3) chk($sformatf("loopback word%0d", got), data_out, lb_words[got]);
                if (got == 0) chk("loopback first latency", c, 8);
                else          chk($sformatf("loopback spacing%0d", got), c - last_cyc, 8);
                last_cyc = c;
                got++;
            end
        end
        chk("loopback word count", got, 3);
        enable = 1'b0; serial_in = 1'b0; data_ready = 1'b0;

        // T4: overrun with ready low, set beats clear on the same edge
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        chk("T4 first word", data_out, 8'h12);
        chk("T4 first valid", data_valid, 1'b1);
        send_word(8'h34, 1'b0, 1'b0, 1'b1);
        chk("T4 data held", data_out, 8'h12);
        chk("T4 valid held", data_valid, 1'b1);
        chk("T4 overrun set over clr", overrun, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("T4 overrun cleared", overrun, 1'b0);
        chk("T4 valid after clr", data_valid, 1'b1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("T4 valid after ready", data_valid, 1'b0);
        chk("T4 data after ready", data_out, 8'h12);

        // T5: completion and transfer on the same edge
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        chk("T5 pending valid", data_valid, 1'b1);
        send_word(8'h56, 1'b0, 1'b1, 1'b0);
        chk("T5 new word", data_out, 8'h56);
        chk("T5 valid stays", data_valid, 1'b1);
        chk("T5 no overrun", overrun, 1'b0);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("T5 drained", data_valid, 1'b0);

        // T6: asynchronous reset mid-word with a word pending
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("T6 pending", data_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1; serial_in = 1'b1;
            tick();
        end
        chk("T6 busy mid-word", busy, 1'b1);
        enable = 1'b0; serial_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("T6 rst data_out", data_out, 8'h00);
        chk("T6 rst data_valid", data_valid, 1'b0);
        chk("T6 rst busy", busy, 1'b0);
        chk("T6 rst overrun", overrun, 1'b0);
        #2 rst = 1'b1;
        send_word(8'hC3, 1'b1, 1'b1, 1'b0);
        chk("T6 next word", data_out, 8'hC3);
        chk("T6 next valid", data_valid, 1'b1);
        chk("T6 next busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
